// File: rtl/vga_timing_table.sv
// Programmable VGA timing table; applies a selected set only on a frame boundary.
// Define VGA_TIMING_CHECK_EN to reject degenerate entries at apply time.
module vga_timing_table #(
  parameter  int H_W     = 12,
  parameter  int V_W     = 11,
  parameter  int NUM_RES = 4,
  localparam int IDX_W   = (NUM_RES > 1) ? $clog2(NUM_RES) : 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             req_i,
  input  logic [IDX_W-1:0] res_idx_i,
  input  logic             frame_end_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [3:0]       wr_field_i,
  input  logic [15:0]      wr_data_i,
  output logic [H_W-1:0]   hd_o,
  output logic [H_W-1:0]   hf_o,
  output logic [H_W-1:0]   hr_o,
  output logic [H_W-1:0]   hb_o,
  output logic [V_W-1:0]   vd_o,
  output logic [V_W-1:0]   vf_o,
  output logic [V_W-1:0]   vr_o,
  output logic [V_W-1:0]   vb_o,
  output logic [H_W+1:0]   h_total_o,
  output logic [V_W+1:0]   v_total_o,
  output logic [7:0]       freq_int_o,
  output logic [7:0]       freq_frac_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;

  localparam logic [31:0] NR = NUM_RES;

  localparam int DH [4][4] = '{
    '{800, 40, 128, 88}, '{640, 16, 96, 48},
    '{1024, 24, 136, 160}, '{1280, 48, 112, 248}};
  localparam int DV [4][4] = '{
    '{600, 1, 4, 23}, '{480, 10, 2, 33},
    '{768, 3, 6, 29}, '{1024, 1, 3, 38}};
  localparam int DFI [4] = '{40, 25, 65, 108};
  localparam int DFF [4] = '{0, 45, 0, 0};

  function automatic int de(input int i);
    return (i < 4) ? i : 0;
  endfunction

  logic [H_W-1:0] th_q [NUM_RES][4];
  logic [V_W-1:0] tv_q [NUM_RES][4];
  logic [7:0]     tfi_q [NUM_RES];
  logic [7:0]     tff_q [NUM_RES];

  logic [H_W-1:0] oh_q [4];
  logic [V_W-1:0] ov_q [4];
  logic [H_W+1:0] ht_q;
  logic [V_W+1:0] vt_q;
  logic [7:0]     fi_q, ff_q;
  logic           valid_q, done_q, err_q;
  logic [IDX_W-1:0] idx_q;
  state_t         state_q, st_cur;

  logic wr_ok, is_h, is_v, is_fi, is_ff, req_ok, ent_ok;
  logic unused_wr_hi;

  assign unused_wr_hi = ^wr_data_i[15:H_W];

  assign req_ok = {{(32-IDX_W){1'b0}}, res_idx_i} < NR;
  assign wr_ok  = wr_en_i && (wr_field_i <= 4'd9)
               && ({{(32-IDX_W){1'b0}}, wr_idx_i} < NR);
  assign is_h   = !wr_field_i[3] && !wr_field_i[2];
  assign is_v   = !wr_field_i[3] && wr_field_i[2];
  assign is_fi  = wr_field_i == 4'd8;
  assign is_ff  = wr_field_i == 4'd9;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < NUM_RES; i++) begin
        for (int f = 0; f < 4; f++) begin
          th_q[i][f] <= H_W'(DH[de(i)][f]);
          tv_q[i][f] <= V_W'(DV[de(i)][f]);
        end
        tfi_q[i] <= 8'(DFI[de(i)]);
        tff_q[i] <= 8'(DFF[de(i)]);
      end
    end else if (wr_ok) begin
      unique case (1'b1)
        is_h:  th_q[wr_idx_i][wr_field_i[1:0]] <= wr_data_i[H_W-1:0];
        is_v:  tv_q[wr_idx_i][wr_field_i[1:0]] <= wr_data_i[V_W-1:0];
        is_fi: tfi_q[wr_idx_i] <= wr_data_i[7:0];
        is_ff: tff_q[wr_idx_i] <= wr_data_i[7:0];
        default: ;
      endcase
    end
  end

`ifdef VGA_TIMING_CHECK_EN
  assign ent_ok = (th_q[idx_q][0] != '0) && (th_q[idx_q][2] != '0)
               && (tv_q[idx_q][0] != '0) && (tv_q[idx_q][2] != '0)
               && ((tfi_q[idx_q] | tff_q[idx_q]) != 8'd0);
`else
  assign ent_ok = 1'b1;
`endif

  // The apply cycle is the pending cycle in which the switch may proceed.
  always_comb begin
    st_cur = state_q;
    if (state_q == PEND && (!valid_q || frame_end_i)) st_cur = APPLY;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ht_q    <= '0;
      vt_q    <= '0;
      fi_q    <= '0;
      ff_q    <= '0;
      for (int f = 0; f < 4; f++) begin
        oh_q[f] <= '0;
        ov_q[f] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (st_cur)
        IDLE: begin
          if (req_i && req_ok) begin
            idx_q   <= res_idx_i;
            state_q <= PEND;
          end else if (req_i) begin
            err_q <= 1'b1;
          end
        end
        PEND: ;
        APPLY: begin
          state_q <= IDLE;
          if (ent_ok) begin
            for (int f = 0; f < 4; f++) begin
              oh_q[f] <= th_q[idx_q][f];
              ov_q[f] <= tv_q[idx_q][f];
            end
            ht_q <= {2'b0, th_q[idx_q][0]} + {2'b0, th_q[idx_q][1]}
                  + {2'b0, th_q[idx_q][2]} + {2'b0, th_q[idx_q][3]};
            vt_q <= {2'b0, tv_q[idx_q][0]} + {2'b0, tv_q[idx_q][1]}
                  + {2'b0, tv_q[idx_q][2]} + {2'b0, tv_q[idx_q][3]};
            fi_q    <= tfi_q[idx_q];
            ff_q    <= tff_q[idx_q];
            valid_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hd_o        = oh_q[0];
  assign hf_o        = oh_q[1];
  assign hr_o        = oh_q[2];
  assign hb_o        = oh_q[3];
  assign vd_o        = ov_q[0];
  assign vf_o        = ov_q[1];
  assign vr_o        = ov_q[2];
  assign vb_o        = ov_q[3];
  assign h_total_o   = ht_q;
  assign v_total_o   = vt_q;
  assign freq_int_o  = fi_q;
  assign freq_frac_o = ff_q;
  assign valid_o     = valid_q;
  assign busy_o      = state_q == PEND;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_vga_timing_table.sv
// Scoreboard bench for vga_timing_table (NUM_RES=5 so an out-of-range
// index exists and entry 4 exercises the copy-of-e0 default).
module tb_vga_timing_table;

  localparam int H_W = 12;
  localparam int V_W = 11;
  localparam int NR  = 5;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic req = 1'b0, fe = 1'b0, wr_en = 1'b0;
  logic [2:0] res_idx = '0, wr_idx = '0;
  logic [3:0] wr_field = '0;
  logic [15:0] wr_data = '0;
  logic [H_W-1:0] hd_o, hf_o, hr_o, hb_o;
  logic [V_W-1:0] vd_o, vf_o, vr_o, vb_o;
  logic [H_W+1:0] h_total_o;
  logic [V_W+1:0] v_total_o;
  logic [7:0] freq_int_o, freq_frac_o;
  logic valid_o, busy_o, done_o, err_o;

  vga_timing_table #(.H_W(H_W), .V_W(V_W), .NUM_RES(NR)) dut (
    .clk_i(clk), .arstn_i(arstn), .req_i(req), .res_idx_i(res_idx),
    .frame_end_i(fe), .wr_en_i(wr_en), .wr_idx_i(wr_idx),
    .wr_field_i(wr_field), .wr_data_i(wr_data),
    .hd_o(hd_o), .hf_o(hf_o), .hr_o(hr_o), .hb_o(hb_o),
    .vd_o(vd_o), .vf_o(vf_o), .vr_o(vr_o), .vb_o(vb_o),
    .h_total_o(h_total_o), .v_total_o(v_total_o),
    .freq_int_o(freq_int_o), .freq_frac_o(freq_frac_o),
    .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    bit valid;
    int cyc;
    int v[12];
  } exp_t;

  exp_t q[$];
  exp_t cur, e, m;
  int vectors = 0;
  int miscompares = 0;
  int act[12];
  string nm[12] = '{"hd", "hf", "hr", "hb", "vd", "vf", "vr", "vb",
                    "h_total", "v_total", "freq_int", "freq_frac"};

  task automatic chk(input string n, input int a, input int x);
    vectors++;
    if (a != x) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, a, x, cyc);
    end
  endtask

  function automatic exp_t mk(input int hd, hf, hr, hb, vd, vf, vr, vb,
                              input int ht, vt, fi, ff);
    exp_t r;
    r.is_err = 1'b0;
    r.valid  = 1'b1;
    r.cyc    = 0;
    r.v = '{hd, hf, hr, hb, vd, vf, vr, vb, ht, vt, fi, ff};
    return r;
  endfunction

  always @(negedge clk) begin
    if (arstn && (done_o || err_o)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        m = q.pop_front();
        act = '{hd_o, hf_o, hr_o, hb_o, vd_o, vf_o, vr_o, vb_o,
                h_total_o, v_total_o, freq_int_o, freq_frac_o};
        chk("err_pulse", int'(err_o), int'(m.is_err));
        chk("done_pulse", int'(done_o), int'(!m.is_err));
        chk("latency_cycle", cyc, m.cyc);
        chk("busy_after", int'(busy_o), 0);
        chk("valid", int'(valid_o), int'(m.valid));
        for (int k = 0; k < 12; k++) chk(nm[k], act[k], m.v[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int idx);
    req = 1'b1;
    res_idx = 3'(idx);
    tick();
    req = 1'b0;
  endtask

  task automatic frame_end();
    fe = 1'b1;
    tick();
    fe = 1'b0;
  endtask

  task automatic wr(input int idx, input int f, input int d);
    wr_en = 1'b1;
    wr_idx = 3'(idx);
    wr_field = 4'(f);
    wr_data = 16'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    chk("drain_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic push_done(input exp_t x, input int lat);
    e = x;
    e.cyc = cyc + lat;
    q.push_back(e);
    cur = x;
  endtask

  task automatic push_err();
    e = cur;
    e.is_err = 1'b1;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_hd", int'(hd_o), 0);
    chk("rst_vb", int'(vb_o), 0);
    chk("rst_h_total", int'(h_total_o), 0);
    chk("rst_freq", int'({freq_int_o, freq_frac_o}), 0);
    chk("rst_flags", int'({valid_o, busy_o, done_o, err_o}), 0);
    arstn = 1'b1;
    tick();

    // cold start: no valid set, so no frame boundary is needed
    push_done(mk(800, 40, 128, 88, 600, 1, 4, 23, 1056, 628, 40, 0), 2);
    request(0);
    chk("t1_busy", int'(busy_o), 1);
    drain();

    request(1);
    repeat (4) tick();
    chk("t2_busy_held", int'(busy_o), 1);
    chk("t2_hd_hold", int'(hd_o), 800);
    push_done(mk(640, 16, 96, 48, 480, 10, 2, 33, 800, 525, 25, 45), 1);
    frame_end();
    drain();

    push_err();
    request(5);
    drain();

    fe = 1'b1;
    request(3);
    fe = 1'b0;
    request(4);
    repeat (3) tick();
    chk("t3_busy_held", int'(busy_o), 1);
    chk("t3_hd_hold", int'(hd_o), 640);
    push_done(mk(1280, 48, 112, 248, 1024, 1, 3, 38, 1688, 1066, 108, 0), 1);
    frame_end();
    drain();
    repeat (3) tick();
    chk("t3_idle_after", int'(busy_o), 0);

    wr(2, 0, 1280);
    wr(2, 10, 5);
    wr(5, 0, 7);
    chk("t4_write_no_out", int'(hd_o), 1280);
    request(2);
    push_done(mk(1280, 24, 136, 160, 768, 3, 6, 29, 1600, 806, 65, 0), 1);
    fe = 1'b1;
    wr(2, 3, 0);
    fe = 1'b0;
    drain();
    request(2);
    push_done(mk(1280, 24, 136, 0, 768, 3, 6, 29, 1440, 806, 65, 0), 1);
    frame_end();
    drain();

    wr(4, 9, 16'h0180);
    request(4);
    push_done(mk(800, 40, 128, 88, 600, 1, 4, 23, 1056, 628, 40, 128), 1);
    frame_end();
    drain();

    wr(3, 2, 0);
    request(3);
`ifdef VGA_TIMING_CHECK_EN
    push_err();
`else
    push_done(mk(1280, 48, 0, 248, 1024, 1, 3, 38, 1576, 1066, 108, 0), 1);
`endif
    frame_end();
    drain();

    request(0);
    chk("t6_busy_pre", int'(busy_o), 1);
    arstn = 1'b0;
    #1;
    chk("t6_valid", int'(valid_o), 0);
    chk("t6_busy", int'(busy_o), 0);
    chk("t6_hd", int'(hd_o), 0);
    tick();
    arstn = 1'b1;
    repeat (3) tick();
    chk("t6_no_resume", int'(busy_o), 0);
    push_done(mk(1024, 24, 136, 160, 768, 3, 6, 29, 1344, 806, 65, 0), 2);
    request(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
